// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : Oversampled UART receiver (8N1 by default) with a one-entry
//               output buffer, framing-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int c_cnt_w = $clog2(OVERSAMPLE);
    localparam int c_idx_w = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full_m1 = c_cnt_w'(OVERSAMPLE - 1);
    localparam logic [c_idx_w-1:0] c_last    = c_idx_w'(DATA_BITS - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [1:0]           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   r_idx;
    logic [DATA_BITS-1:0] r_shift;

    logic [1:0]           w_state_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_idx_w-1:0]   w_idx_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_byte_done;
    logic                 w_stop_bad;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_w'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_byte_done = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            c_idle: begin
                w_cnt_nxt = '0;
                if (!r_rx_s) begin
                    w_state_nxt = c_start;
                end
            end
            c_start: begin
                if (r_cnt == c_half_m1) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = r_rx_s ? c_idle : c_data;
                end
            end
            c_data: begin
                if (r_cnt == c_full_m1) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = r_rx_s;
                    if (r_idx == c_last) begin
                        w_state_nxt = c_stop;
                    end else begin
                        w_idx_nxt = r_idx + c_idx_w'(1);
                    end
                end
            end
            c_stop: begin
                // Returning to idle at mid-stop lets a back-to-back start bit be caught.
                if (r_cnt == c_full_m1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_idle;
                    w_byte_done = r_rx_s;
                    w_stop_bad  = ~r_rx_s;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_state    <= c_idle;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            busy      <= (w_state_nxt != c_idle);
            frame_err <= w_stop_bad;
            overrun   <= 1'b0;
            if (w_byte_done) begin
                // A byte taken on this same edge frees the buffer for the new one.
                if (!data_valid || data_ready) begin
                    data_out   <= r_shift;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Directed self-checking bench for uart_rx_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    int fe_cnt = 0, fe_long = 0, ov_cnt = 0, ov_long = 0, busy_cnt = 0;
    logic fe_prev = 1'b0, ov_prev = 1'b0;
    logic [7:0] acc [$];

    uart_rx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) begin
            fe_cnt++;
            if (fe_prev) fe_long++;
        end
        if (overrun) begin
            ov_cnt++;
            if (ov_prev) ov_long++;
        end
        fe_prev = frame_err;
        ov_prev = overrun;
        if (busy) busy_cnt++;
        if (data_valid && data_ready) acc.push_back(data_out);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) drive(b[i], 16);
        drive(stop_bit, 16);
    endtask

    task automatic take_one();
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
    endtask

    initial begin
        int fe0, ov0, b0, n0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_out",   32'(data_out),   32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_frame_err",  32'(frame_err),  32'h0);
        check("rst_overrun",    32'(overrun),    32'h0);
        reset = 1'b0;
        drive(1'b1, 5);

        // 0xA5 held in buffer
        fe0 = fe_cnt;
        send_frame(8'hA5, 1'b1);
        check("a5_valid", 32'(data_valid), 32'h1);
        check("a5_data",  32'(data_out),   32'hA5);
        check("a5_busy",  32'(busy),       32'h0);
        check("a5_ferr",  32'(fe_cnt - fe0), 32'h0);
        take_one();
        check("a5_taken", 32'(data_valid), 32'h0);
        drive(1'b1, 4);

        // Start-bit glitch
        fe0 = fe_cnt; ov0 = ov_cnt; b0 = busy_cnt;
        drive(1'b0, 4);
        drive(1'b1, 30);
        check("glitch_busy_cycles", 32'(busy_cnt - b0), 32'd8);
        check("glitch_valid", 32'(data_valid), 32'h0);
        check("glitch_ferr",  32'(fe_cnt - fe0), 32'h0);
        check("glitch_ovr",   32'(ov_cnt - ov0), 32'h0);

        // Framing error then good frame
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        drive(1'b1, 24);
        check("ferr_count", 32'(fe_cnt - fe0), 32'h1);
        check("ferr_valid", 32'(data_valid), 32'h0);
        send_frame(8'h55, 1'b1);
        check("after_ferr_valid", 32'(data_valid), 32'h1);
        check("after_ferr_data",  32'(data_out),   32'h55);
        take_one();
        drive(1'b1, 4);

        // Overrun
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        check("ovr_before", 32'(ov_cnt - ov0), 32'h0);
        send_frame(8'h22, 1'b1);
        check("ovr_count", 32'(ov_cnt - ov0), 32'h1);
        check("ovr_data",  32'(data_out),     32'h11);
        check("ovr_valid", 32'(data_valid),   32'h1);
        take_one();
        check("ovr_taken", 32'(data_valid), 32'h0);
        drive(1'b1, 4);

        // Back-to-back frames, consumer always ready
        data_ready = 1'b1;
        ov0 = ov_cnt;
        n0 = acc.size();
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        drive(1'b1, 5);
        check("b2b_count", 32'(acc.size() - n0), 32'd3);
        if (acc.size() >= n0 + 3) begin
            check("b2b_0", 32'(acc[n0]),     32'h01);
            check("b2b_1", 32'(acc[n0 + 1]), 32'h02);
            check("b2b_2", 32'(acc[n0 + 2]), 32'h03);
        end
        check("b2b_ovr", 32'(ov_cnt - ov0), 32'h0);
        data_ready = 1'b0;
        check("b2b_last_data", 32'(data_out), 32'h03);

        // Reset mid-frame during data bit 4 (0xF0: remaining bits are all ones)
        drive(1'b0, 16);
        drive(1'b0, 64);
        drive(1'b1, 8);
        check("pre_rst_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #2;
        check("mid_rst_busy",     32'(busy),       32'h0);
        check("mid_rst_data_out", 32'(data_out),   32'h0);
        check("mid_rst_valid",    32'(data_valid), 32'h0);
        check("mid_rst_ferr",     32'(frame_err),  32'h0);
        check("mid_rst_ovr",      32'(overrun),    32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 8 + 48 + 16 + 8);
        check("post_rst_valid", 32'(data_valid), 32'h0);
        check("post_rst_busy",  32'(busy),       32'h0);
        send_frame(8'h7E, 1'b1);
        check("post_rst_7e_valid", 32'(data_valid), 32'h1);
        check("post_rst_7e_data",  32'(data_out),   32'h7E);

        check("ferr_single_cycle", 32'(fe_long), 32'h0);
        check("ovr_single_cycle",  32'(ov_long), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
